// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and helpers for the uart_tx arbiter slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int GRANT_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick; search starts just after ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [GRANT_W(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]          gnt,
    output logic [GRANT_W(NREQ)-1:0] idx
);

    localparam int GW = GRANT_W(NREQ);

    logic          found;
    logic [GW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = GW'((int'(ptr) + off) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin scheduler sharing one uart_tx among NREQ requesters,
//           with inter-frame gap and start-acknowledge watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic [GRANT_W(NREQ)-1:0] grant_id,
    output logic                     arb_busy,
    output logic                     timeout_err,
    output logic [15:0]              frame_count
);

    localparam int GW    = GRANT_W(NREQ);
    localparam int WD_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Expiry is decided one cycle early so the registered pulse lands
    // exactly ACK_TIMEOUT cycles after START (requires ACK_TIMEOUT >= 2).
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(ACK_TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              tx_start_q, tx_start_d;
    logic              arb_busy_q, arb_busy_d;
    logic              timeout_err_q, timeout_err_d;

    logic [NREQ-1:0]   w_gnt;
    logic [GW-1:0]     w_idx;
    logic              w_handshake;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req (req_valid),
        .ptr (last_grant_q),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    assign req_ready   = (state_q == ST_IDLE) ? w_gnt : '0;
    assign w_handshake = |(req_valid & req_ready);

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        wd_cnt_d      = wd_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frame_count_d = frame_count_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_handshake) begin
                    tx_data_d    = req_data[w_idx*DATA_W +: DATA_W];
                    grant_id_d   = w_idx;
                    last_grant_d = w_idx;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                wd_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                    if (wd_cnt_d == c_wd_last) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    frame_count_d = frame_count_q + 16'd1;
                    gap_cnt_d     = '0;
                    state_d       = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (int'(gap_cnt_q) >= GAP_CYCLES - 1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tx_start_d = (state_d == ST_START);
        arb_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
            last_grant_q  <= GW'(NREQ - 1);
            wd_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            frame_count_q <= '0;
            tx_start_q    <= 1'b0;
            arb_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_count_q <= frame_count_d;
            tx_start_q    <= tx_start_d;
            arb_busy_q    <= arb_busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign arb_busy    = arb_busy_q;
    assign timeout_err = timeout_err_q;
    assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Self-checking bench: directed and randomized frames against a
//           cycle-level reference model of the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 3;
    localparam int ACK = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;
    int m_last;
    int m_fc;
    int obs_gid;

    uart_tx_arbiter #(
        .NREQ        (N),
        .DATA_W      (8),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: first valid requester after 'last', wrapping; -1 if none.
    function automatic int pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= N; off++) begin
            if (v[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] r;
        r = 4'b0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left in an IDLE cycle, 1 time unit after the clock edge.
    task automatic run_frame(input logic [3:0] v, input logic [31:0] d, input bit to);
        int w;
        int dly;
        int len;
        logic [7:0] byte_exp;
        req_valid = v;
        req_data  = d;
        tx_busy   = 1'b0;
        #1;
        w = pick(v, m_last);
        chk("idle_ready", req_ready, onehot(w));
        chk("idle_arb_busy", arb_busy, 0);
        chk("idle_tx_start", tx_start, 0);
        tick();
        m_last   = w;
        byte_exp = d[w*8 +: 8];
        obs_gid  = grant_id;
        chk("start_pulse", tx_start, 1);
        chk("start_tx_data", tx_data, byte_exp);
        chk("start_grant_id", grant_id, w);
        chk("start_ready", req_ready, 0);
        chk("start_timeout", timeout_err, 0);
        req_valid = 4'($urandom);
        req_data  = $urandom;
        if (to) begin
            for (int j = 1; j < ACK; j++) begin
                tick();
                chk("wd_tx_start", tx_start, 0);
                chk("wd_quiet", timeout_err, 0);
                chk("wd_ready", req_ready, 0);
            end
            tick();
            chk("wd_pulse", timeout_err, 1);
            chk("wd_idle", arb_busy, 0);
            chk("wd_frame_count", frame_count, m_fc);
        end else begin
            dly = $urandom_range(0, 6);
            len = $urandom_range(1, 8);
            tick();
            chk("start_once", tx_start, 0);
            for (int j = 0; j < dly; j++) begin
                chk("wb_arb_busy", arb_busy, 1);
                tick();
            end
            tx_busy = 1'b1;
            for (int j = 0; j < len; j++) begin
                req_valid = 4'($urandom);
                #1;
                chk("frame_ready", req_ready, 0);
                chk("frame_tx_data", tx_data, byte_exp);
                chk("frame_count_hold", frame_count, m_fc);
                tick();
            end
            tx_busy = 1'b0;
            chk("done_count_hold", frame_count, m_fc);
            tick();
            m_fc = (m_fc + 1) & 16'hFFFF;
            chk("frame_count_inc", frame_count, m_fc);
            for (int g = 0; g < GAP; g++) begin
                req_valid = 4'($urandom_range(1, 15));
                tx_busy   = 1'($urandom);
                #1;
                chk("gap_ready", req_ready, 0);
                chk("gap_arb_busy", arb_busy, 1);
                tick();
            end
            tx_busy = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_frame_count", frame_count, 0);
        repeat (3) tick();
        rst    = 1'b1;
        m_last = N - 1;
        m_fc   = 0;
        tick();

        // Single requester 2 with 0xA5.
        run_frame(4'b0100, 32'h00A5_0000, 1'b0);
        chk("single_count", frame_count, 1);

        // Idle with nothing valid.
        req_valid = '0;
        #1;
        chk("idle_none_ready", req_ready, 0);
        tick();

        // Watchdog: tx_busy never rises.
        run_frame(4'b0001, 32'h0000_003C, 1'b1);

        // Reset asserted asynchronously during WAIT_DONE.
        req_valid = 4'b0010;
        req_data  = 32'h0000_5A00;
        #1;
        tick();
        req_valid = '0;
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        chk("mid_frame_busy", arb_busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_tx_start", tx_start, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_grant_id", grant_id, 0);
        chk("arst_arb_busy", arb_busy, 0);
        chk("arst_timeout", timeout_err, 0);
        chk("arst_frame_count", frame_count, 0);
        chk("arst_ready", req_ready, 0);
        #2;
        rst     = 1'b1;
        tx_busy = 1'b0;
        m_last  = N - 1;
        m_fc    = 0;
        tick();

        // Fairness: all requesters valid for 8 frames.
        for (int k = 0; k < 8; k++) begin
            run_frame(4'b1111, $urandom, 1'b0);
            chk("fair_order", obs_gid, k % N);
        end

        // Randomized traffic, occasionally timing out.
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                #1;
                chk("rand_idle_ready", req_ready, 0);
                tick();
            end
            run_frame(4'($urandom_range(1, 15)), $urandom, ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
